// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_fetch_pkg : shared types and constants for the fetch front end |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned TMO_CNT_W  = 8;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ERR   = 3'd5
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_timeout_ctr : request-cycle counter with terminal-count flag |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_timeout_ctr
  import mips_fetch_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  // Flag fires in the LIMIT-th counted cycle so the owner leaves on that edge.
  localparam logic [TMO_CNT_W-1:0] c_tc_val = TMO_CNT_W'(LIMIT - 1);

  logic [TMO_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_tc_val);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_unit : PC capture, imem req/ack, decode hand-off       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_redirect,
  output logic              o_pc_adv,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic              o_fetch_err
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic              w_tmo_tc;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_addr_ld;
  logic              w_capture;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              r_fetch_err;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_instr;

  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_tmo_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A spent timeout budget beats a redirect so DRAIN never outlives the counter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (i_redirect)              w_state_nxt = ST_ISSUE;
        else if (i_pc[1:0] != 2'b00) w_state_nxt = ST_ERR;
        else                         w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_imem_ack)      w_state_nxt = i_redirect ? ST_ISSUE : ST_HOLD;
        else if (w_tmo_tc)   w_state_nxt = ST_ERR;
        else if (i_redirect) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_imem_ack)    w_state_nxt = ST_ISSUE;
        else if (w_tmo_tc) w_state_nxt = ST_ERR;
      end
      ST_HOLD: begin
        if (i_redirect || i_instr_ready) w_state_nxt = ST_ISSUE;
      end
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pc_adv  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    w_addr_ld = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        w_cnt_clr = 1'b1;
        w_addr_ld = 1'b1;
      end
      ST_FETCH: begin
        w_cnt_en  = ~i_imem_ack;
        w_capture = i_imem_ack & ~i_redirect;
      end
      ST_DRAIN: w_cnt_en = ~i_imem_ack;
      ST_HOLD:  o_pc_adv = i_instr_ready & ~i_redirect;
      default:  ;
    endcase
  end

  // Status outputs are decoded from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_imem_addr   <= '0;
      r_instr_pc    <= '0;
      r_instr       <= DATA_W'(NOP_INSTR);
    end else begin
      r_imem_req    <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
      r_instr_valid <= (w_state_nxt == ST_HOLD);
      r_fetch_err   <= (w_state_nxt == ST_ERR);
      if (w_addr_ld) begin
        r_imem_addr <= i_pc;
      end
      if (w_capture) begin
        r_instr    <= i_imem_rdata;
        r_instr_pc <= r_imem_addr;
      end
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed bench for instr_fetch_unit          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic        i_redirect;
  logic        o_pc_adv;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        o_fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pc          (i_pc),
    .i_redirect    (i_redirect),
    .o_pc_adv      (o_pc_adv),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_fetch_err   (o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_pc = '0; i_redirect = 1'b0; i_imem_ack = 1'b0;
    i_imem_rdata = '0; i_instr_ready = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_instr_valid); end
    checks++; if (o_fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_fetch_err); end
    checks++; if (o_pc_adv !== 1'b0) begin errors++; $display("FAIL rst_adv: got %b want 0", o_pc_adv); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", o_imem_addr); end
    checks++; if (o_instr_pc !== 32'h0) begin errors++; $display("FAIL rst_ipc: got %h want 0", o_instr_pc); end
    checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", o_instr); end
  endtask

  task automatic test_zero_wait();
    apply_reset();
    i_pc = 32'h0; i_imem_rdata = 32'h2008_0005; i_imem_ack = 1'b1; i_instr_ready = 1'b1;
    tick();
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL zw_issue_req: got %b want 0", o_imem_req); end
    tick();
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr: got %h want 0", o_imem_addr); end
    checks++; if (o_pc_adv !== 1'b0) begin errors++; $display("FAIL zw_adv_fetch: got %b want 0", o_pc_adv); end
    tick();
    checks++; if (o_instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", o_instr_valid); end
    checks++; if (o_instr !== 32'h2008_0005) begin errors++; $display("FAIL zw_instr: got %h want 20080005", o_instr); end
    checks++; if (o_instr_pc !== 32'h0) begin errors++; $display("FAIL zw_ipc: got %h want 0", o_instr_pc); end
    checks++; if (o_pc_adv !== 1'b1) begin errors++; $display("FAIL zw_adv: got %b want 1", o_pc_adv); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_hold: got %b want 0", o_imem_req); end
    i_imem_ack = 1'b0;
    tick();
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_drop: got %b want 0", o_instr_valid); end
    checks++; if (o_pc_adv !== 1'b0) begin errors++; $display("FAIL zw_adv_once: got %b want 0", o_pc_adv); end
  endtask

  task automatic test_delayed_ack();
    int adv_cnt;
    adv_cnt = 0;
    apply_reset();
    i_pc = 32'h100; i_imem_rdata = 32'h8C08_0004;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL da_req[%0d]: got %b want 1", i, o_imem_req); end
      checks++; if (o_imem_addr !== 32'h100) begin errors++; $display("FAIL da_addr[%0d]: got %h want 100", i, o_imem_addr); end
      checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL da_early_valid[%0d]: got %b want 0", i, o_instr_valid); end
      i_imem_ack = (i == 3);
      tick();
    end
    i_imem_ack = 1'b0;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL da_req_after: got %b want 0", o_imem_req); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (o_instr_valid !== 1'b1) begin errors++; $display("FAIL da_valid[%0d]: got %b want 1", j, o_instr_valid); end
      checks++; if (o_instr !== 32'h8C08_0004) begin errors++; $display("FAIL da_instr[%0d]: got %h want 8c080004", j, o_instr); end
      checks++; if (o_instr_pc !== 32'h100) begin errors++; $display("FAIL da_ipc[%0d]: got %h want 100", j, o_instr_pc); end
      i_instr_ready = (j == 2);
      #1;
      if (o_pc_adv === 1'b1) adv_cnt++;
      tick();
    end
    i_instr_ready = 1'b0;
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL da_valid_drop: got %b want 0", o_instr_valid); end
    checks++; if (adv_cnt !== 1) begin errors++; $display("FAIL da_adv_count: got %0d want 1", adv_cnt); end
  endtask

  task automatic test_redirect_fetch();
    apply_reset();
    i_pc = 32'h20; i_imem_rdata = 32'hBAD0_BAD0;
    tick(); tick();
    checks++; if (o_imem_addr !== 32'h20) begin errors++; $display("FAIL rf_addr: got %h want 20", o_imem_addr); end
    i_redirect = 1'b1;
    tick();
    i_redirect = 1'b0; i_pc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rf_drain_req[%0d]: got %b want 1", i, o_imem_req); end
      checks++; if (o_imem_addr !== 32'h20) begin errors++; $display("FAIL rf_drain_addr[%0d]: got %h want 20", i, o_imem_addr); end
      i_imem_ack = (i == 1);
      tick();
    end
    i_imem_ack = 1'b0;
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rf_discard: got %b want 0", o_instr_valid); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rf_issue_req: got %b want 0", o_imem_req); end
    tick();
    checks++; if (o_imem_addr !== 32'h40) begin errors++; $display("FAIL rf_new_addr: got %h want 40", o_imem_addr); end
    i_imem_ack = 1'b1; i_imem_rdata = 32'h8C09_0040;
    tick();
    i_imem_ack = 1'b0;
    checks++; if (o_instr !== 32'h8C09_0040) begin errors++; $display("FAIL rf_instr: got %h want 8c090040", o_instr); end
    checks++; if (o_instr_pc !== 32'h40) begin errors++; $display("FAIL rf_ipc: got %h want 40", o_instr_pc); end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    i_pc = 32'h80; i_imem_ack = 1'b1; i_imem_rdata = 32'h1111_2222;
    tick(); tick(); tick();
    i_imem_ack = 1'b0;
    checks++; if (o_instr_valid !== 1'b1) begin errors++; $display("FAIL rh_valid: got %b want 1", o_instr_valid); end
    i_instr_ready = 1'b1; i_redirect = 1'b1;
    #1;
    checks++; if (o_pc_adv !== 1'b0) begin errors++; $display("FAIL rh_adv: got %b want 0", o_pc_adv); end
    tick();
    i_redirect = 1'b0; i_pc = 32'hC0;
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rh_valid_drop: got %b want 0", o_instr_valid); end
    checks++; if (o_pc_adv !== 1'b0) begin errors++; $display("FAIL rh_adv_issue: got %b want 0", o_pc_adv); end
    tick();
    i_instr_ready = 1'b0;
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rh_refetch_req: got %b want 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'hC0) begin errors++; $display("FAIL rh_refetch_addr: got %h want c0", o_imem_addr); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    i_pc = 32'h6;
    tick();
    checks++; if (o_fetch_err !== 1'b0) begin errors++; $display("FAIL ma_err_early: got %b want 0", o_fetch_err); end
    tick();
    checks++; if (o_fetch_err !== 1'b1) begin errors++; $display("FAIL ma_err: got %b want 1", o_fetch_err); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL ma_req: got %b want 0", o_imem_req); end
    i_pc = 32'h8;
    tick(); tick();
    checks++; if (o_fetch_err !== 1'b1) begin errors++; $display("FAIL ma_sticky: got %b want 1", o_fetch_err); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL ma_req_sticky: got %b want 0", o_imem_req); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    apply_reset();
    i_pc = 32'h10;
    tick(); tick();
    for (int k = 0; k < 20; k++) begin
      if (o_imem_req !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d want 8", n); end
    checks++; if (o_fetch_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", o_fetch_err); end
  endtask

  task automatic test_ack_at_timeout();
    apply_reset();
    i_pc = 32'h30; i_imem_rdata = 32'h0000_0020;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      i_imem_ack = (i == 7);
      tick();
    end
    i_imem_ack = 1'b0;
    checks++; if (o_fetch_err !== 1'b0) begin errors++; $display("FAIL at_err: got %b want 0", o_fetch_err); end
    checks++; if (o_instr_valid !== 1'b1) begin errors++; $display("FAIL at_valid: got %b want 1", o_instr_valid); end
    checks++; if (o_instr !== 32'h0000_0020) begin errors++; $display("FAIL at_instr: got %h want 00000020", o_instr); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    i_pc = 32'h200; i_imem_rdata = 32'h2409_0001;
    tick(); tick();
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL ar_req_before: got %b want 1", o_imem_req); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr: got %h want 0", o_imem_addr); end
    checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", o_instr_valid); end
    tick();
    i_rst_n = 1'b1; i_pc = 32'h204; i_imem_ack = 1'b1;
    tick(); tick();
    checks++; if (o_imem_addr !== 32'h204) begin errors++; $display("FAIL ar_restart_addr: got %h want 204", o_imem_addr); end
    tick();
    i_imem_ack = 1'b0;
    checks++; if (o_instr_pc !== 32'h204) begin errors++; $display("FAIL ar_restart_ipc: got %h want 204", o_instr_pc); end
    checks++; if (o_instr !== 32'h2409_0001) begin errors++; $display("FAIL ar_restart_instr: got %h want 24090001", o_instr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_redirect_fetch();
    test_redirect_hold();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch front end between the program counter register and the decode stage. Captures the current PC and issues a request/acknowledge transaction to instruction memory. Holds the returned word for decode, then pulses a PC-advance enable back to the program counter. Also handles branch/jump redirects, misaligned PCs and memory timeouts.

## Interface
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction width
- `TIMEOUT_CYC`, 255, maximum request cycles without ack before error (8-bit counter, 1..255)

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset; asynchronous, active-low
- `i_pc`  in  ADDR_W  current PC from program counter register
- `i_redirect`  in  1  single-cycle pulse; PC is being loaded with a branch/jump target this edge
- `o_pc_adv`  out  1  PC register write enable for sequential advance
- `o_imem_req`  out  1  memory request, held until ack
- `o_imem_addr`  out  ADDR_W  registered request address
- `i_imem_ack`  in  1  memory ack; `i_imem_rdata` valid same cycle
- `i_imem_rdata`  in  DATA_W  instruction word
- `o_instr`  out  DATA_W  instruction to decode
- `o_instr_pc`  out  ADDR_W  address of `o_instr`
- `o_instr_valid`  out  1  `o_instr` valid
- `i_instr_ready`  in  1  decode accepts instruction
- `o_fetch_err`  out  1  sticky error (misaligned or timeout)

## Operation
- **FSM states:** IDLE, ISSUE, FETCH, DRAIN, HOLD, ERR.
- **IDLE:** entered on reset; goes to ISSUE on the next edge.
- **ISSUE (one cycle):**
  - Load `o_imem_addr` <= `i_pc` and clear the timeout counter.
  - If `i_pc[1:0]` != 0, go to ERR; otherwise go to FETCH.
  - If `i_redirect`, stay in ISSUE and recapture next cycle.
- **FETCH:** `o_imem_req`=1 with `o_imem_addr` stable.
  - ack, no redirect: capture rdata into `o_instr` and `o_imem_addr` into `o_instr_pc`; go to HOLD.
  - ack with redirect: discard data; go to ISSUE.
  - No ack with redirect: go to DRAIN.
  - No ack, counter reaches `TIMEOUT_CYC`: go to ERR.
- **DRAIN:** `o_imem_req`=1 until ack; data is discarded. On ack go to ISSUE. Timeout applies as in FETCH. Further redirects are ignored.
- **HOLD:** `o_instr_valid`=1.
  - `i_redirect`: drop valid and go to ISSUE; no advance. Redirect has priority over ready.
  - `i_instr_ready` without redirect: `o_pc_adv`=1 (combinational, this cycle only); go to ISSUE.
- **ERR:** all request/valid outputs are 0 and `o_fetch_err`=1. ERR is left only by reset.
- `o_pc_adv` = (state==HOLD) & `i_instr_ready` & ~`i_redirect`. It is never asserted in other states.
- **Reset values (asynchronous assert):**
  - State IDLE; counter 0.
  - `o_imem_req`, `o_instr_valid`, `o_fetch_err`, `o_pc_adv` = 0.
  - `o_imem_addr`, `o_instr_pc` = 0.
  - `o_instr` = 32'h0000_0000 (NOP).
- **Reset mid-transaction:** the request drops immediately and any later ack is not tracked. Memory must tolerate an abandoned request.

## Timing
- The ISSUE cycle starts fetching `i_pc`, which is stable while not in HOLD-with-advance.
- **Zero-wait memory:** ISSUE n, FETCH/req n+1 with ack at n+1, HOLD/valid n+2. Ready at n+2 gives advance at n+2 and ISSUE at n+3. Throughput is 1 instruction per 3 cycles.
- Each wait cycle of the memory adds one cycle. Decode back-pressure extends HOLD with `o_instr`/`o_instr_pc` stable.
- **Timeout:** the counter increments each FETCH/DRAIN cycle without ack. Counter == `TIMEOUT_CYC` with no ack gives ERR on that edge, so the request was high for exactly `TIMEOUT_CYC` cycles.
- An ack in the timeout cycle wins over the timeout.
- All outputs are registered except `o_pc_adv`.

## Structure
- Package `mips_fetch_pkg` holds:
  - the state enum;
  - `NOP_INSTR` = 32'h0;
  - `ADDR_W`/`DATA_W` defaults;
  - the timeout counter width (8).
- Optional sub-module `fetch_timeout_ctr`: 8-bit counter with clear, enable and terminal-count flag.
- Everything else lives in a single module.

## Test plan
- **Reset then zero-wait ack:** `i_pc`=0x0, rdata=0x2008_0005, ready=1. Required response: addr 0x0, valid at cycle 3 with `o_instr`=0x2008_0005 and `o_instr_pc`=0, and a single `o_pc_adv` pulse.
- **Ack delayed 4 cycles, ready held low 3 cycles:** request is high for 4 cycles with addr stable; valid and data are stable for 3 cycles; `o_pc_adv` pulses once.
- **Redirect in FETCH, ack 2 cycles later:** DRAIN discards that data. The next ISSUE captures the new `i_pc`=0x40, and only the 0x40 instruction reaches decode.
- **Redirect and ready together in HOLD:** `o_pc_adv` stays 0, valid drops, and a refetch starts from the new PC.
- **Misaligned `i_pc`=0x6:** `o_fetch_err`=1 two cycles after reset and no request is issued. **No ack with `TIMEOUT_CYC`=8:** request is high 8 cycles, then err=1.
- **Async reset asserted during FETCH:** all outputs return to reset values immediately. After release, fetch restarts from the current `i_pc`.
